// File: rtl/clr_en_pipe_reg_if.sv
`default_nettype none
// ============================================================================
//  Module   : clr_en_pipe_reg_if
//  Brief    : Flow-control and data bundle for clr_en_pipe_reg.
//  Revision : 1.0 - initial release
// ============================================================================
interface clr_en_pipe_reg_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 3
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             iEn;
    logic             iClr;
    logic             iVld;
    logic [WIDTH-1:0] iDat;
    logic             oRdy;
    logic             oVld;
    logic [WIDTH-1:0] oDat;
    logic             iRdy;
    logic [CNT_W-1:0] oCnt;

    // master = the side that feeds and drains the pipe
    modport master (
        output iEn, iClr, iVld, iDat, iRdy,
        input  oRdy, oVld, oDat, oCnt
    );

    modport slave (
        input  iEn, iClr, iVld, iDat, iRdy,
        output oRdy, oVld, oDat, oCnt
    );
endinterface
`default_nettype wire

// File: rtl/clr_en_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : clr_en_pipe_reg
//  Brief    : DEPTH-stage valid/ready register pipeline with bubble
//             collapsing, global freeze and synchronous flush-to-init.
//  Revision : 1.0 - initial release
// ============================================================================
module clr_en_pipe_reg #(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 3,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  wire logic            clk,
    input  wire logic            rst,
    clr_en_pipe_reg_if.slave     bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;
    logic [WIDTH-1:0] dat_q [DEPTH];
    logic [WIDTH-1:0] dat_d [DEPTH];

    logic [DEPTH-1:0] w_acc;
    logic [DEPTH-1:0] w_src_vld;
    logic [WIDTH-1:0] w_src_dat [DEPTH];
    logic [CNT_W-1:0] w_cnt;

    // A stage can take new data if it or any stage downstream of it is empty,
    // or if the whole tail is full and the output is being drained.
    always_comb begin : p_acc
        logic run;
        run                = ~vld_q[DEPTH-1] | bus.iRdy;
        w_acc              = '0;
        w_acc[DEPTH-1]     = run;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            run      = ~vld_q[k] | run;
            w_acc[k] = run;
        end
    end

    always_comb begin : p_src
        w_src_vld    = '0;
        w_src_vld[0] = bus.iVld;
        w_src_dat[0] = bus.iDat;
        for (int k = 1; k < DEPTH; k++) begin
            w_src_vld[k] = vld_q[k-1];
            w_src_dat[k] = dat_q[k-1];
        end
    end

    always_comb begin : p_next
        vld_d = vld_q;
        dat_d = dat_q;
        if (bus.iClr) begin
            vld_d = '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_d[k] = INI_DATA;
            end
        end else if (bus.iEn) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (w_acc[k]) begin
                    vld_d[k] = w_src_vld[k];
                    // an incoming bubble leaves the old payload in place
                    if (w_src_vld[k]) begin
                        dat_d[k] = w_src_dat[k];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                dat_q[k] <= INI_DATA;
            end
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    always_comb begin : p_cnt
        w_cnt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_cnt = w_cnt + CNT_W'(vld_q[k]);
        end
    end

    assign bus.oRdy = w_acc[0] & bus.iEn & ~bus.iClr;
    assign bus.oVld = vld_q[DEPTH-1] & bus.iEn & ~bus.iClr;
    assign bus.oDat = dat_q[DEPTH-1];
    assign bus.oCnt = w_cnt;

endmodule
`default_nettype wire

// File: tb/tb_clr_en_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clr_en_pipe_reg
//  Brief    : Self-checking bench for clr_en_pipe_reg (DEPTH=3, INI_DATA=1).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clr_en_pipe_reg;
    localparam int          WIDTH = 32;
    localparam int          DEPTH = 3;
    localparam logic [31:0] INI   = 32'h1;

    typedef struct {
        int          pos;
        logic [31:0] data;
    } item_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    n_checks = 0;
    int    n_errors = 0;
    item_t sb [$];

    clr_en_pipe_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    clr_en_pipe_reg #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .INI_DATA (INI)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: each held beat has a slot position; the oldest sits furthest
    // downstream. Beats slide one slot per edge into any slot freed this edge.
    function automatic void model_edge(input logic r, en, clr, vld, input logic [31:0] dat,
                                       input logic rdy);
        item_t t;
        int    lim;
        if (r || clr) begin
            sb.delete();
            return;
        end
        if (!en) return;
        if (sb.size() > 0 && sb[0].pos == DEPTH - 1 && rdy) void'(sb.pop_front());
        for (int i = 0; i < sb.size(); i++) begin
            lim = (i == 0) ? DEPTH - 1 : sb[i-1].pos - 1;
            t   = sb[i];
            if (t.pos < lim) t.pos++;
            sb[i] = t;
        end
        if (vld && (sb.size() == 0 || sb[sb.size()-1].pos > 0)) begin
            t.pos  = 0;
            t.data = dat;
            sb.push_back(t);
        end
    endfunction

    // Called at posedge+1: drive, check combinational outputs mid-cycle, clock.
    task automatic step(input logic r, en, clr, vld, input logic [31:0] dat, input logic rdy);
        logic exp_rdy, exp_vld;
        rst      = r;
        bus.iEn  = en;
        bus.iClr = clr;
        bus.iVld = vld;
        bus.iDat = dat;
        bus.iRdy = rdy;
        @(negedge clk);
        if (!r) begin
            exp_rdy = en & ~clr & ((sb.size() < DEPTH) | rdy);
            exp_vld = en & ~clr & (sb.size() > 0) && (sb[0].pos == DEPTH - 1);
            check("oRdy", {31'b0, bus.oRdy}, {31'b0, exp_rdy});
            check("oVld", {31'b0, bus.oVld}, {31'b0, exp_vld});
            check("oCnt", 32'(bus.oCnt), 32'(sb.size()));
            if (exp_vld) check("oDat", bus.oDat, sb[0].data);
        end
        @(posedge clk);
        model_edge(r, en, clr, vld, dat, rdy);
        #1;
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, rdy);
    endtask

    initial begin
        bus.iEn = 1'b1; bus.iClr = 1'b0; bus.iVld = 1'b0; bus.iDat = '0; bus.iRdy = 1'b0;
        @(posedge clk); #1;

        // 1: reset state
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        check("rst_oDat", bus.oDat, INI);
        check("rst_oCnt", 32'(bus.oCnt), 32'd0);
        idle(1, 1'b0);

        // 2: back-to-back stream
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'd10 + 32'(i), 1'b1);
        idle(5, 1'b1);

        // 3: stalled output fills the pipe, then drains in order
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'd20 + 32'(i), 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'd23, 1'b0);
        check("full_oCnt", 32'(bus.oCnt), 32'd3);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'd23, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'd24, 1'b1);
        idle(5, 1'b1);

        // 4: freeze with two beats held
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'd30, 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b1, 32'd31, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'd99, 1'b1);
        check("frz_oCnt", 32'(bus.oCnt), 32'd2);
        idle(5, 1'b1);

        // 5: flush a full pipe
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 32'd40 + 32'(i), 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 32'd43, 1'b1);
        check("clr_oDat", bus.oDat, INI);
        check("clr_oCnt", 32'(bus.oCnt), 32'd0);
        idle(5, 1'b1);

        // 6: random traffic including mid-stream reset and flush
        for (int i = 0; i < 4000; i++) begin
            step(($urandom % 150) == 0,
                 ($urandom % 8) != 0,
                 ($urandom % 60) == 0,
                 1'($urandom),
                 $urandom,
                 ($urandom % 3) != 0);
        end
        idle(5, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
